// File: rtl/per_sft_rst_sequencer_if.sv
// RCC-side handshake bundle of the per-peripheral software-reset sequencer.
// The master side is the RCC register file; the slave side is the sequencer.
interface per_sft_rst_sequencer_if;
    logic rst_req;
    logic testmode;
    logic sft_rst_n;
    logic arcg_on;
    logic rst_busy;
    logic rst_done;

    modport master (
        output rst_req,
        output testmode,
        input  sft_rst_n,
        input  arcg_on,
        input  rst_busy,
        input  rst_done
    );

    modport slave (
        input  rst_req,
        input  testmode,
        output sft_rst_n,
        output arcg_on,
        output rst_busy,
        output rst_done
    );
endinterface

// File: rtl/per_sft_rst_sequencer.sv
// Turns an RCC software-reset request into a timed sft_rst_n pulse with a settle window.
// Define PER_SFT_RST_AUTOCLR_EN when rst_req is a self-clearing one-cycle write pulse.
module per_sft_rst_sequencer #(
    parameter int MIN_RST_CYCLES      = 4,
    parameter int RELEASE_WAIT_CYCLES = 2
) (
    input logic                    i_clk,
    input logic                    sys_rst_n,
    per_sft_rst_sequencer_if.slave bus
);

    localparam int MAX_CYCLES = (MIN_RST_CYCLES > RELEASE_WAIT_CYCLES) ?
                                MIN_RST_CYCLES : RELEASE_WAIT_CYCLES;
    localparam int CNT_W = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] ASSERT_LOAD  = CNT_W'(MIN_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RELEASE_LOAD = CNT_W'(RELEASE_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSERT,
        S_HOLD,
        S_RELEASE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             sft_rst_n_q, sft_rst_n_d;
    logic             arcg_on_q, arcg_on_d;
    logic             rst_busy_q, rst_busy_d;
    logic             rst_done_q, rst_done_d;

    // NOTE: every next-value gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        rst_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                pend_d = 1'b0;
                if (bus.rst_req) begin
                    state_d = S_ASSERT;
                    cnt_d   = ASSERT_LOAD;
                end
            end

            S_ASSERT: begin
                pend_d = 1'b0;
`ifdef PER_SFT_RST_AUTOCLR_EN
                // Each write pulse restarts the minimum low width.
                if (bus.rst_req) begin
                    cnt_d = ASSERT_LOAD;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d = S_RELEASE;
                    cnt_d   = RELEASE_LOAD;
                end
`else
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (bus.rst_req) begin
                    state_d = S_HOLD;
                end else begin
                    state_d = S_RELEASE;
                    cnt_d   = RELEASE_LOAD;
                end
`endif
            end

            S_HOLD: begin
                if (!bus.rst_req) begin
                    state_d = S_RELEASE;
                    cnt_d   = RELEASE_LOAD;
                end
            end

            S_RELEASE: begin
                // A request landing on the final settle cycle still counts as pending.
                if (cnt_q != '0) begin
                    cnt_d  = cnt_q - CNT_ONE;
                    pend_d = pend_q | bus.rst_req;
                end else if (pend_q || bus.rst_req) begin
                    state_d = S_ASSERT;
                    cnt_d   = ASSERT_LOAD;
                    pend_d  = 1'b0;
                end else begin
                    state_d    = S_IDLE;
                    pend_d     = 1'b0;
                    rst_done_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                pend_d  = 1'b0;
            end
        endcase

        if (bus.testmode) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            pend_d     = 1'b0;
            rst_done_d = 1'b0;
        end

        // Outputs are decoded from the next state so they register with it.
        sft_rst_n_d = !((state_d == S_ASSERT) || (state_d == S_HOLD));
        arcg_on_d   = (state_d != S_IDLE);
        rst_busy_d  = (state_d != S_IDLE);
    end

    // NOTE: non-blocking assignments so every flop samples the same pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            sft_rst_n_q <= 1'b1;
            arcg_on_q   <= 1'b0;
            rst_busy_q  <= 1'b0;
            rst_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            sft_rst_n_q <= sft_rst_n_d;
            arcg_on_q   <= arcg_on_d;
            rst_busy_q  <= rst_busy_d;
            rst_done_q  <= rst_done_d;
        end
    end

    assign bus.sft_rst_n = sft_rst_n_q;
    assign bus.arcg_on   = arcg_on_q;
    assign bus.rst_busy  = rst_busy_q;
    assign bus.rst_done  = rst_done_q;

endmodule
